divisor_multicanal: RTL and testbench

- Parametrised successor to the single-output fixed divider: N_CH independent divider channels driven from one input clock.
- Each channel has a runtime-programmable divisor, a per-channel enable, a one-cycle `tick` strobe (clock enable for downstream logic) and a registered square output `clk_out`.
- Divisor changes are double-buffered so they never produce a runt period.
- Sits between the board clock and the VGA timing, blink and debounce logic; a global `sync` phase-aligns all channels.

---
 rtl/divisor_pkg.sv | 15 +
 rtl/divisor_multicanal_if.sv | 28 ++
 rtl/divisor_canal.sv | 84 ++++++++
 rtl/divisor_multicanal.sv | 48 ++++
 tb/tb_divisor_multicanal.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared helpers for the multi-channel clock divider: minimum-divisor clamp
// and channel-select width.
package divisor_pkg;

    localparam int MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/divisor_multicanal_if.sv
// Control/status bundle of the multi-channel divider: enables, sync, divisor
// write port and the per-channel tick/clk_out/pending outputs.
interface divisor_multicanal_if
    import divisor_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 26,
    parameter int CH_W  = ch_w(N_CH)
);
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  pending;

    modport master (
        output en, sync, wr_en, wr_ch, wr_div,
        input  tick, clk_out, pending
    );

    modport slave (
        input  en, sync, wr_en, wr_ch, wr_div,
        output tick, clk_out, pending
    );
endinterface

// File: rtl/divisor_canal.sv
// One divider channel: counter, double-buffered divisor, tick strobe and
// registered square output.
module divisor_canal
    import divisor_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 3
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_pending
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_out;

    logic [CNT_W-1:0] w_div_new;
    logic [CNT_W-1:0] w_pend_val;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic             w_pend_flag;
    logic             w_wrap;
    logic             w_apply;
    logic             w_pending_nxt;
    logic             w_tick_nxt;
    logic             w_clk_nxt;

    always_comb begin
        w_div_new     = CNT_W'(clamp_div(32'(i_wr_div)));
        // A write landing this cycle takes precedence over the buffered value.
        w_pend_flag   = i_wr | r_pending;
        w_pend_val    = i_wr ? w_div_new : r_div_pend;
        w_wrap        = (r_cnt == r_div_act - CNT_W'(1));
        w_apply       = i_sync | ~i_en | w_wrap;
        w_cnt_nxt     = '0;
        w_div_nxt     = r_div_act;
        w_pending_nxt = w_pend_flag;
        w_tick_nxt    = 1'b0;
        if (w_apply) begin
            w_div_nxt     = w_pend_flag ? w_pend_val : r_div_act;
            w_pending_nxt = 1'b0;
        end
        if (!i_sync && i_en) begin
            if (w_wrap) w_tick_nxt = 1'b1;
            else        w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
        // High for the first floor(D/2) counts of the period, forced low when idle.
        w_clk_nxt = i_en && (w_cnt_nxt < (w_div_nxt >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= CNT_W'(DEF_DIV);
            r_div_pend <= CNT_W'(DEF_DIV);
            r_pending  <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div_act <= w_div_nxt;
            if (i_wr) r_div_pend <= w_div_new;
            r_pending <= w_pending_nxt;
            r_tick    <= w_tick_nxt;
            r_clk_out <= w_clk_nxt;
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
    assign o_pending = r_pending;

endmodule

// File: rtl/divisor_multicanal.sv
// N_CH independent programmable clock-enable dividers sharing one clock,
// a global sync and a single divisor write port.
module divisor_multicanal
    import divisor_pkg::*;
#(
    parameter int IN_F    = 75000000,
    parameter int OUT_F   = 25000000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = int'(clamp_div(32'(IN_F / OUT_F))),
    parameter int CH_W    = ch_w(N_CH)
)
(
    input  logic                  clk,
    input  logic                  rst,
    divisor_multicanal_if.slave   bus
);

    logic [N_CH-1:0] w_wr;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_clk_out;
    logic [N_CH-1:0] w_pending;

    // Select values beyond N_CH-1 match no channel, so such writes are dropped.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_wr[g] = bus.wr_en && (bus.wr_ch == CH_W'(g));

        divisor_canal #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_canal (
            .clk       (clk),
            .rst       (rst),
            .i_en      (bus.en[g]),
            .i_sync    (bus.sync),
            .i_wr      (w_wr[g]),
            .i_wr_div  (bus.wr_div),
            .o_tick    (w_tick[g]),
            .o_clk_out (w_clk_out[g]),
            .o_pending (w_pending[g])
        );
    end

    assign bus.tick    = w_tick;
    assign bus.clk_out = w_clk_out;
    assign bus.pending = w_pending;

endmodule

// File: tb/tb_divisor_multicanal.sv
// Scoreboard bench for divisor_multicanal: stimulus queues timed expectations,
// monitors compare them against the outputs when their time comes.
module tb_divisor_multicanal;

    localparam int S_TICK = 0;
    localparam int S_CLK  = 1;
    localparam int S_PEND = 2;

    typedef struct {
        int    key;
        int    sel;
        int    ch;
        logic  v;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    event async_ev;

    divisor_multicanal_if #(.N_CH(4), .CNT_W(26), .CH_W(2)) bus ();

    divisor_multicanal u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) t <= t + 1;

    function automatic void exp_key(int key, int sel, int ch, logic v, string nm);
        exp_t e;
        e.key = key; e.sel = sel; e.ch = ch; e.v = v; e.nm = nm;
        sb.push_back(e);
    endfunction

    function automatic void exp_at(int dt, int sel, int ch, logic v, string nm);
        exp_key(t + dt, sel, ch, v, nm);
    endfunction

    function automatic void check_key(int key);
        logic a;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].key == key) begin
                case (sb[i].sel)
                    S_TICK:  a = bus.tick[sb[i].ch];
                    S_CLK:   a = bus.clk_out[sb[i].ch];
                    default: a = bus.pending[sb[i].ch];
                endcase
                n_chk++;
                if (a !== sb[i].v) begin
                    n_fail++;
                    $display("FAIL %s ch%0d at t=%0d: got %b, want %b",
                             sb[i].nm, sb[i].ch, t, a, sb[i].v);
                end
                sb.delete(i);
            end
        end
    endfunction

    always @(negedge clk) check_key(t);
    always @(async_ev)    check_key(-1);

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.en = 4'hF; bus.sync = 1'b0; bus.wr_en = 1'b0;
        bus.wr_ch = 2'd0; bus.wr_div = '0;
        step(2);
        for (int c = 0; c < 4; c++) begin
            exp_at(1, S_TICK, c, 1'b0, "rst_tick");
            exp_at(1, S_CLK,  c, 1'b0, "rst_clk");
            exp_at(1, S_PEND, c, 1'b0, "rst_pend");
        end
        step(1);
        rst = 1'b0;

        // Default divisor 3 on every channel
        for (int c = 0; c < 4; c++)
            for (int d = 1; d <= 6; d++) begin
                exp_at(d, S_TICK, c, (d % 3 == 0), "def_tick");
                exp_at(d, S_CLK,  c, (d % 3 == 0), "def_clk");
            end
        step(7);

        // Channel 1 -> 10 while cnt=1; applied at the current wrap
        bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_div = 26'd10;
        exp_at(1, S_PEND, 1, 1'b1, "d10_pend");
        exp_at(2, S_PEND, 1, 1'b0, "d10_pend_clr");
        for (int d = 2; d <= 12; d++) begin
            exp_at(d, S_TICK, 1, (d == 2 || d == 12), "d10_tick");
            exp_at(d, S_CLK,  1, (d <= 6 || d == 12), "d10_clk");
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 1) continue;
            exp_at(1, S_PEND, c, 1'b0, "other_pend");
            for (int d = 2; d <= 5; d++) begin
                exp_at(d, S_TICK, c, (d == 2 || d == 5), "other_tick");
                exp_at(d, S_CLK,  c, (d == 2 || d == 5), "other_clk");
            end
        end
        step(1);
        bus.wr_en = 1'b0;
        step(12);

        // Channel 2: divisor 1 written on its wrap (bypass), then 0; both clamp to 2
        bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_div = 26'd1;
        exp_at(1, S_PEND, 2, 1'b0, "d1_bypass_pend");
        for (int d = 1; d <= 4; d++) begin
            exp_at(d, S_TICK, 2, (d % 2 == 1), "d2_tick");
            exp_at(d, S_CLK,  2, (d % 2 == 1), "d2_clk");
        end
        step(1);
        bus.wr_div = 26'd0;
        exp_at(1, S_PEND, 2, 1'b1, "d0_pend");
        exp_at(2, S_PEND, 2, 1'b0, "d0_pend_clr");
        exp_at(4, S_TICK, 2, 1'b1, "d0_tick");
        step(1);
        bus.wr_en = 1'b0;
        step(2);

        // Channel 3: 8 then 5 before the wrap, only 5 takes effect
        bus.wr_en = 1'b1; bus.wr_ch = 2'd3; bus.wr_div = 26'd8;
        exp_at(1, S_PEND, 3, 1'b1, "d8_pend");
        step(1);
        bus.wr_div = 26'd5;
        exp_at(1, S_PEND, 3, 1'b1, "d5_pend");
        step(1);
        bus.wr_en = 1'b0;
        exp_at(1, S_PEND, 3, 1'b0, "d5_pend_clr");
        for (int d = 1; d <= 6; d++) begin
            exp_at(d, S_TICK, 3, (d == 1 || d == 6), "d5_tick");
            exp_at(d, S_CLK,  3, (d <= 2 || d == 6), "d5_clk");
        end
        step(10);
        // Write on the wrap cycle of channel 3: no pending cycle
        bus.wr_en = 1'b1; bus.wr_div = 26'd4;
        exp_at(1, S_PEND, 3, 1'b0, "wrap_byp_pend");
        for (int d = 1; d <= 5; d++)
            exp_at(d, S_TICK, 3, (d == 1 || d == 5), "wrap_byp_tick");
        step(1);

        // Channels 0/1 programmed while disabled, started out of phase, then sync
        bus.en = 4'b1100; bus.wr_ch = 2'd0; bus.wr_div = 26'd4;
        for (int d = 1; d <= 2; d++) begin
            exp_at(d, S_TICK, 0, 1'b0, "dis_tick");
            exp_at(d, S_CLK,  0, 1'b0, "dis_clk");
            exp_at(d, S_PEND, 0, 1'b0, "dis_pend");
        end
        exp_at(2, S_PEND, 1, 1'b0, "dis_pend1");
        step(1);
        bus.wr_ch = 2'd1; bus.wr_div = 26'd6;
        step(1);
        bus.wr_en = 1'b0; bus.en = 4'b1101;
        step(1);
        bus.en = 4'hF;
        step(2);
        bus.sync = 1'b1;
        exp_at(1, S_TICK, 0, 1'b0, "sync_tick0");
        exp_at(1, S_TICK, 1, 1'b0, "sync_tick1");
        exp_at(1, S_CLK,  0, 1'b1, "sync_clk0");
        exp_at(1, S_CLK,  1, 1'b1, "sync_clk1");
        exp_at(3, S_CLK,  0, 1'b0, "sync_clk0_lo");
        exp_at(5, S_TICK, 0, 1'b1, "sync_d4_tick");
        exp_at(7, S_TICK, 1, 1'b1, "sync_d6_tick");
        exp_at(12, S_TICK, 0, 1'b0, "pre_align0");
        exp_at(12, S_TICK, 1, 1'b0, "pre_align1");
        exp_at(13, S_TICK, 0, 1'b1, "align_tick0");
        exp_at(13, S_TICK, 1, 1'b1, "align_tick1");
        step(1);
        bus.sync = 1'b0;
        step(13);
        bus.en = 4'b1110;
        for (int d = 1; d <= 4; d++) begin
            exp_at(d, S_TICK, 0, 1'b0, "en0_tick");
            exp_at(d, S_CLK,  0, 1'b0, "en0_clk");
        end
        step(4);

        // Channel 2 at D=10, pending write at cnt=6, async reset at cnt=7
        bus.en = 4'b1011; bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_div = 26'd10;
        step(1);
        bus.wr_en = 1'b0; bus.en = 4'hF;
        step(6);
        bus.wr_en = 1'b1; bus.wr_div = 26'd7;
        exp_at(1, S_PEND, 2, 1'b1, "pre_rst_pend");
        exp_at(1, S_TICK, 2, 1'b0, "pre_rst_tick");
        step(1);
        bus.wr_en = 1'b0;
        #2;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_key(-1, S_TICK, c, 1'b0, "async_tick");
            exp_key(-1, S_CLK,  c, 1'b0, "async_clk");
            exp_key(-1, S_PEND, c, 1'b0, "async_pend");
        end
        #1;
        -> async_ev;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_at(1, S_PEND, c, 1'b0, "post_rst_pend");
            exp_at(3, S_TICK, c, 1'b1, "post_rst_tick");
        end
        for (int d = 1; d <= 6; d++)
            exp_at(d, S_TICK, 2, (d % 3 == 0), "post_rst_d3");
        exp_at(3, S_CLK, 2, 1'b1, "post_rst_clk_hi");
        exp_at(4, S_CLK, 2, 1'b0, "post_rst_clk_lo");
        step(8);

        foreach (sb[i]) begin
            n_fail++;
            $display("FAIL %s ch%0d never compared: want %b", sb[i].nm, sb[i].ch, sb[i].v);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
